// File: rtl/msu_io_v2.sv
// msu_io_v2: MSU-1 register block for the SNES core with an HPS-fed
// data read-ahead FIFO and a stepped volume ramp.
module msu_io_v2 #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         RAMP_DIV   = 256,
  parameter logic [2:0] REVISION   = 3'd2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [23:0] ADDR,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic [15:0] track_out,
  output logic        trig_play,
  input  logic        track_mounting,
  input  logic        track_missing,
  output logic        audio_playing,
  output logic        audio_repeat,
  output logic [7:0]  volume_out,
  output logic [31:0] data_seek_addr,
  output logic        data_seek,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        data_end,
  output logic [31:0] data_fetch_addr
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(RAMP_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic          r_wr_q, r_rd_q;
  logic [23:0]   r_seek;
  logic [31:0]   r_seek_addr, r_fetch;
  logic          r_seek_p, r_trig;
  logic          r_play, r_rep, r_busy;
  logic [7:0]    r_dout, r_trk_lo, r_tgt, r_vol;
  logic [15:0]   r_track;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_div;

  logic       w_acc, w_wr_lvl, w_rd_lvl, w_wr, w_rd;
  logic [2:0] w_reg;
  logic       w_full, w_empty, w_push, w_pop, w_seek, w_tc;
  logic       w_unused;

  assign w_acc    = ENABLE & ~ADDR[22] & (ADDR[15:3] == 13'h0400);
  assign w_wr_lvl = w_acc & ~WR_N;
  assign w_rd_lvl = w_acc & ~RD_N;
  assign w_wr     = w_wr_lvl & ~r_wr_q;
  assign w_rd     = w_rd_lvl & ~r_rd_q & ~w_wr_lvl;
  assign w_reg    = ADDR[2:0];
  assign w_full   = (r_cnt == FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign w_push   = data_valid & data_ready;
  assign w_pop    = w_rd & (w_reg == 3'd1) & ~r_busy & ~w_empty;
  assign w_seek   = w_wr & (w_reg == 3'd3);
  assign w_tc     = (r_div == DIV_TC);
  assign w_unused = ^{ADDR[23], ADDR[21:16]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_q      <= 1'b0;
      r_rd_q      <= 1'b0;
      r_seek      <= '0;
      r_seek_addr <= '0;
      r_seek_p    <= 1'b0;
      r_trig      <= 1'b0;
      r_play      <= 1'b0;
      r_rep       <= 1'b0;
      r_dout      <= '0;
      r_trk_lo    <= '0;
      r_track     <= '0;
      r_tgt       <= '0;
    end else begin
      r_wr_q   <= w_wr_lvl;
      r_rd_q   <= w_rd_lvl;
      r_seek_p <= w_seek;
      r_trig   <= w_wr & (w_reg == 3'd5);
      if (w_wr) begin
        case (w_reg)
          3'd0: r_seek[7:0]   <= DIN;
          3'd1: r_seek[15:8]  <= DIN;
          3'd2: r_seek[23:16] <= DIN;
          3'd3: r_seek_addr   <= {DIN, r_seek};
          3'd4: r_trk_lo      <= DIN;
          3'd5: begin
            r_track <= {DIN, r_trk_lo};
            r_play  <= 1'b0;
            r_rep   <= 1'b0;
          end
          3'd6: r_tgt <= DIN;
          3'd7: begin
            if (!track_mounting) begin
              r_play <= DIN[0];
              r_rep  <= DIN[1];
            end
          end
        endcase
      end
      if (w_rd) begin
        case (w_reg)
          3'd0: r_dout <= {r_busy, track_mounting, r_rep,
                           r_play, track_missing, REVISION};
          3'd1: r_dout <= w_pop ? r_mem[r_rp] : 8'h00;
          3'd2: r_dout <= 8'h53;
          3'd3: r_dout <= 8'h2D;
          3'd4: r_dout <= 8'h4D;
          3'd5: r_dout <= 8'h53;
          3'd6: r_dout <= 8'h55;
          3'd7: r_dout <= 8'h31;
        endcase
      end
    end
  end

  // A seek flushes the FIFO and overrides any same-cycle push or pop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_fetch <= '0;
      r_busy  <= 1'b0;
    end else if (w_seek) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_fetch <= {DIN, r_seek};
      r_busy  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wp    <= r_wp + 1'b1;
        r_fetch <= r_fetch + 32'd1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
      if (r_busy && (w_full || data_end))
        r_busy <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !w_seek)
      r_mem[r_wp] <= data_in;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_div <= '0;
      r_vol <= '0;
    end else if (RAMP_DIV == 0) begin
      r_vol <= r_tgt;
    end else begin
      r_div <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc && (r_vol != r_tgt))
        r_vol <= (r_vol < r_tgt) ? r_vol + 1'b1 : r_vol - 1'b1;
    end
  end

  assign DOUT            = r_dout;
  assign track_out       = r_track;
  assign trig_play       = r_trig;
  assign audio_playing   = r_play;
  assign audio_repeat    = r_rep;
  assign volume_out      = r_vol;
  assign data_seek_addr  = r_seek_addr;
  assign data_seek       = r_seek_p;
  assign data_ready      = ~w_full & ~r_seek_p;
  assign data_fetch_addr = r_fetch;
endmodule
